// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: requester ports A and B plus the single-port memory side.
// slave is the arbiter's view; master is the view of whoever drives requests and memory data.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              a_valid;
    logic              a_ready;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_rsp_valid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_valid;
    logic              b_ready;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_rsp_valid;
    logic [DATA_W-1:0] b_rdata;
    logic              b_lock;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              lock_timeout;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rsp_valid, a_rdata,
        input  b_valid, b_we, b_addr, b_wdata, b_lock,
        output b_ready, b_rsp_valid, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, lock_timeout,
        input  mem_rdata
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rsp_valid, a_rdata,
        output b_valid, b_we, b_addr, b_wdata, b_lock,
        input  b_ready, b_rsp_valid, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, lock_timeout,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between ports A and B, with a bounded B burst lock.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise B has fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOCK_MAX = 64
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {StArb, StLockB, StForceA} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rsp_a_q, rsp_b_q;
    logic              grant_a, grant_b;
    logic              acc_a, acc_b;
    logic              b_wins;
    logic              timeout;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers which port was accepted last; reset value "B last" lets A win the first conflict.
    logic last_b_q;

    assign b_wins = !last_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_b_q <= 1'b1;
        end else if (acc_a) begin
            last_b_q <= 1'b0;
        end else if (acc_b) begin
            last_b_q <= 1'b1;
        end
    end
`else
    assign b_wins = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StArb: begin
                if (bus.b_valid && (!bus.a_valid || b_wins)) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = bus.a_valid;
                end
                if (grant_b && bus.b_lock) begin
                    state_d = StLockB;
                    cnt_d   = CntW'(1);
                end
            end
            StLockB: begin
                grant_b = bus.b_valid;
                // Dropping b_lock always wins over the timeout.
                if (!bus.b_lock) begin
                    state_d = StArb;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(LOCK_MAX)) begin
                    state_d = StForceA;
                    cnt_d   = '0;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StForceA: begin
                grant_a = bus.a_valid;
                state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    // Nothing is accepted while reset is held, even though the valids are combinational.
    assign acc_a = grant_a & reset;
    assign acc_b = grant_b & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StArb;
            cnt_q   <= '0;
            rsp_a_q <= 1'b0;
            rsp_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_a_q <= acc_a & !bus.a_we;
            rsp_b_q <= acc_b & !bus.b_we;
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (acc_b) begin
            addr_mux  = bus.b_addr;
            wdata_mux = bus.b_wdata;
        end else if (acc_a) begin
            addr_mux  = bus.a_addr;
            wdata_mux = bus.a_wdata;
        end
    end

    assign bus.a_ready      = acc_a;
    assign bus.b_ready      = acc_b;
    assign bus.mem_en       = acc_a | acc_b;
    assign bus.mem_we       = acc_b ? bus.b_we : (acc_a & bus.a_we);
    assign bus.mem_addr     = addr_mux;
    assign bus.mem_wdata    = wdata_mux;
    assign bus.lock_timeout = timeout & reset;

    assign bus.a_rsp_valid  = rsp_a_q;
    assign bus.a_rdata      = rsp_a_q ? bus.mem_rdata : '0;
    assign bus.b_rsp_valid  = rsp_b_q;
    assign bus.b_rdata      = rsp_b_q ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus response scoreboard on a memory model,
// and a second instance with LOCK_MAX=4 for the lock timeout sequence.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) if_m ();
    mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) if_t ();

    mem_arbiter #(.ADDR_W(12), .DATA_W(16), .LOCK_MAX(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (if_m)
    );

    mem_arbiter #(.ADDR_W(12), .DATA_W(16), .LOCK_MAX(4)) dut_t (
        .clk  (clk),
        .reset(reset),
        .bus  (if_t)
    );

    typedef struct {
        logic        av, awe;
        logic [11:0] aaddr;
        logic [15:0] awd;
        logic        bv, bwe;
        logic [11:0] baddr;
        logic [15:0] bwd;
        logic        bl;
        logic        ear, ebr;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    rsp_t        exp_a[$];
    rsp_t        exp_b[$];
    vec_t        vecs[$];
    logic [15:0] model_mem[0:4095];

    function automatic logic [15:0] init_word(input logic [11:0] a);
        return (a == 12'h010) ? 16'h1234 : {4'hD, a};
    endfunction

    // Synchronous single-port memory seen by the main instance.
    logic [15:0] mem[0:4095];
    logic [15:0] rd_q;
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(12'(i));
            mem_init_done <= 1'b1;
        end else if (if_m.mem_en) begin
            if (if_m.mem_we) mem[if_m.mem_addr] <= if_m.mem_wdata;
            else rd_q <= mem[if_m.mem_addr];
        end
    end
    assign if_m.mem_rdata = rd_q;
    assign if_t.mem_rdata = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic awe, input logic [11:0] aaddr,
                                input logic [15:0] awd, input logic bv, input logic bwe,
                                input logic [11:0] baddr, input logic [15:0] bwd,
                                input logic bl, input logic ear, input logic ebr);
        vec_t v;
        v.av = av;  v.awe = awe; v.aaddr = aaddr; v.awd = awd;
        v.bv = bv;  v.bwe = bwe; v.baddr = baddr; v.bwd = bwd;
        v.bl = bl;  v.ear = ear; v.ebr = ebr;
        return v;
    endfunction

    task automatic check_rsp(input string tag);
        logic due;
        due = (exp_a.size() > 0) && (exp_a[0].cyc == cyc);
        chk({tag, "_a_rsp_valid"}, 32'(if_m.a_rsp_valid), 32'(due));
        if (due) begin
            chk({tag, "_a_rdata"}, 32'(if_m.a_rdata), 32'(exp_a[0].data));
            void'(exp_a.pop_front());
        end else begin
            chk({tag, "_a_rdata_idle"}, 32'(if_m.a_rdata), 32'h0);
        end
        due = (exp_b.size() > 0) && (exp_b[0].cyc == cyc);
        chk({tag, "_b_rsp_valid"}, 32'(if_m.b_rsp_valid), 32'(due));
        if (due) begin
            chk({tag, "_b_rdata"}, 32'(if_m.b_rdata), 32'(exp_b[0].data));
            void'(exp_b.pop_front());
        end else begin
            chk({tag, "_b_rdata_idle"}, 32'(if_m.b_rdata), 32'h0);
        end
    endtask

    task automatic drive_m(input vec_t v);
        if_m.a_valid = v.av; if_m.a_we = v.awe; if_m.a_addr = v.aaddr; if_m.a_wdata = v.awd;
        if_m.b_valid = v.bv; if_m.b_we = v.bwe; if_m.b_addr = v.baddr; if_m.b_wdata = v.bwd;
        if_m.b_lock  = v.bl;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        drive_m(v);
        @(negedge clk);
        cyc++;
        check_rsp(tag);
        chk({tag, "_a_ready"}, 32'(if_m.a_ready), 32'(v.ear));
        chk({tag, "_b_ready"}, 32'(if_m.b_ready), 32'(v.ebr));
        chk({tag, "_mem_en"}, 32'(if_m.mem_en), 32'(v.ear | v.ebr));
        chk({tag, "_lock_timeout"}, 32'(if_m.lock_timeout), 32'h0);
        if (v.ebr) begin
            chk({tag, "_mem_addr"}, 32'(if_m.mem_addr), 32'(v.baddr));
            chk({tag, "_mem_we"}, 32'(if_m.mem_we), 32'(v.bwe));
            if (v.bwe) model_mem[v.baddr] = v.bwd;
            else exp_b.push_back('{cyc + 1, model_mem[v.baddr]});
        end else if (v.ear) begin
            chk({tag, "_mem_addr"}, 32'(if_m.mem_addr), 32'(v.aaddr));
            chk({tag, "_mem_we"}, 32'(if_m.mem_we), 32'(v.awe));
            if (v.awe) model_mem[v.aaddr] = v.awd;
            else exp_a.push_back('{cyc + 1, model_mem[v.aaddr]});
        end
    endtask

    task automatic tcyc(input logic av, input logic bv, input logic bl, input logic ear,
                        input logic ebr, input logic eto, input string tag);
        @(posedge clk);
        #1;
        if_t.a_valid = av; if_t.b_valid = bv; if_t.b_lock = bl;
        @(negedge clk);
        chk({tag, "_a_ready"}, 32'(if_t.a_ready), 32'(ear));
        chk({tag, "_b_ready"}, 32'(if_t.b_ready), 32'(ebr));
        chk({tag, "_lock_timeout"}, 32'(if_t.lock_timeout), 32'(eto));
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 4096; i++) model_mem[i] = init_word(12'(i));

        // Reset held with both requesters active: nothing may be accepted.
        drive_m(mk(1, 0, 12'h010, 16'h0, 1, 0, 12'h020, 16'h0, 1, 0, 0));
        if_t.a_valid = 1'b1; if_t.a_we = 1'b0; if_t.a_addr = 12'h0; if_t.a_wdata = 16'h0;
        if_t.b_valid = 1'b1; if_t.b_we = 1'b1; if_t.b_addr = 12'h0; if_t.b_wdata = 16'h0;
        if_t.b_lock  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_a_ready", 32'(if_m.a_ready), 32'h0);
            chk("rst_b_ready", 32'(if_m.b_ready), 32'h0);
            chk("rst_mem_en", 32'(if_m.mem_en), 32'h0);
            chk("rst_a_rsp_valid", 32'(if_m.a_rsp_valid), 32'h0);
            chk("rst_b_rsp_valid", 32'(if_m.b_rsp_valid), 32'h0);
            chk("rst_lock_timeout", 32'(if_m.lock_timeout), 32'h0);
            chk("rst_t_readys", 32'({if_t.a_ready, if_t.b_ready, if_t.mem_en}), 32'h0);
        end
        @(posedge clk);
        #1;
        drive_m(idle);
        if_t.a_valid = 1'b0; if_t.b_valid = 1'b0; if_t.b_lock = 1'b0;
        reset = 1'b1;

        // Conflict right after reset: both read every cycle for 4 cycles.
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            vecs.push_back(mk(1, 0, 12'h020, 16'h0, 1, 0, 12'h030, 16'h0, 0,
                              (i % 2) == 0, (i % 2) == 1));
`else
            vecs.push_back(mk(1, 0, 12'h020, 16'h0, 1, 0, 12'h030, 16'h0, 0, 0, 1));
`endif
        end
        vecs.push_back(idle);
        // Single A read of the preloaded word.
        vecs.push_back(mk(1, 0, 12'h010, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        vecs.push_back(idle);
        // Writes from both ports, read back crosswise.
        vecs.push_back(mk(0, 0, 12'h0, 16'h0, 1, 1, 12'h070, 16'hBEEF, 0, 0, 1));
        vecs.push_back(mk(1, 1, 12'h071, 16'hA5A5, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 12'h070, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 12'h0, 16'h0, 1, 0, 12'h071, 16'h0, 0, 0, 1));
        // A access first so B wins the burst start under either priority scheme.
        vecs.push_back(mk(1, 0, 12'h010, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 0, 12'h040, 16'h0, 1, 1, 12'h100 + 12'(i), 16'hB000 + 16'(i),
                              i < 7, 0, 1));
        end
        vecs.push_back(mk(1, 0, 12'h040, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 0, 12'h100 + 12'(i), 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        end
        // Lock released by dropping b_lock with no B request present.
        vecs.push_back(mk(0, 0, 12'h0, 16'h0, 1, 0, 12'h080, 16'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 12'h081, 16'h0, 0, 0, 12'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h081, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0));
        vecs.push_back(idle);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Reset the cycle after an accepted B read: the response must be dropped.
        apply(mk(0, 0, 12'h0, 16'h0, 1, 0, 12'h050, 16'h0, 0, 0, 1), "rstrd_acc");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_m(idle);
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rstrd_b_rsp_valid", 32'(if_m.b_rsp_valid), 32'h0);
            chk("rstrd_a_rsp_valid", 32'(if_m.a_rsp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(idle, "rstrd_idle");
        apply(mk(1, 0, 12'h050, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0), "rstrd_a_read");
        apply(idle, "rstrd_done");

        // Timeout on the LOCK_MAX=4 instance.
        tcyc(0, 1, 1, 0, 1, 0, "to_start");
        for (int i = 1; i <= 4; i++) tcyc(1, 1, 1, 0, 1, i == 4, $sformatf("to_lock%0d", i));
        tcyc(1, 1, 1, 1, 0, 0, "to_force_a");
        tcyc(1, 1, 0, 0, 1, 0, "to_rearb");
        tcyc(0, 0, 0, 0, 0, 0, "to_idle");

        chk("end_exp_a_empty", 32'(exp_a.size()), 32'h0);
        chk("end_exp_b_empty", 32'(exp_b.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
